gs_butterfly_pipe: RTL and testbench

GS_BUTTERFLY_PIPE -- requirements
Module: gs_butterfly_pipe

---
 rtl/gs_butterfly_pipe.sv | 223 ++++++++++++++++++++++
 tb/tb_gs_butterfly_pipe.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gs_butterfly_pipe.sv
// Gentleman-Sande inverse NTT butterfly, 3-stage pipeline with ready/valid flow control.
// Optional per-beat output halving (multiply by 2^-1 mod q) under macro GS_BFLY_HALVE_EN.
// Barrett constant: mu = floor(2^(2k) / q), k = bit length of q.
module gs_butterfly_pipe #(
  parameter int DATA_W = 64,
  parameter int COEF_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
`ifdef GS_BFLY_HALVE_EN
  input  logic              halve,
`endif
  input  logic [DATA_W-1:0] u,
  input  logic [DATA_W-1:0] v,
  input  logic [COEF_W-1:0] w,
  input  logic [DATA_W-1:0] q,
  input  logic [DATA_W-1:0] mu,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] u_out,
  output logic [DATA_W-1:0] v_out,
  output logic              busy,
  output logic [15:0]       done_cnt
);

  localparam int PROD_W = DATA_W + COEF_W;
  localparam int K_W    = $clog2(DATA_W) + 1;

  function automatic logic [K_W-1:0] bit_len(input logic [DATA_W-1:0] x);
    logic [K_W-1:0] n;
    n = '0;
    for (int i = 0; i < DATA_W; i++) begin
      if (x[i]) n = K_W'(i + 1);
    end
    return n;
  endfunction

  // Classic Barrett: estimate quotient from the top bits, residue lands in [0, 3q), two corrections.
  function automatic logic [DATA_W-1:0] barrett_reduce(
    input logic [PROD_W-1:0] x,
    input logic [DATA_W-1:0] m,
    input logic [DATA_W-1:0] m_mu,
    input logic [K_W-1:0]    k
  );
    logic [PROD_W-1:0] t1;
    logic [PROD_W-1:0] t2;
    logic [PROD_W-1:0] m_w;
    logic [PROD_W-1:0] r;
    m_w = PROD_W'(m);
    t1  = x >> (k - K_W'(1));
    t2  = (t1 * PROD_W'(m_mu)) >> (k + K_W'(1));
    r   = x - t2 * m_w;
    if (r >= m_w) r = r - m_w;
    if (r >= m_w) r = r - m_w;
    return r[DATA_W-1:0];
  endfunction

`ifdef GS_BFLY_HALVE_EN
  function automatic logic [DATA_W-1:0] half_mod(
    input logic [DATA_W-1:0] x,
    input logic [DATA_W-1:0] m
  );
    logic [DATA_W-1:0] t;
    t = x[0] ? (x + m) : x;
    return t >> 1;
  endfunction
`endif

  logic advance;

  logic              vld_p1_q,  vld_p1_d;
  logic [DATA_W-1:0] sum_p1_q,  sum_p1_d;
  logic [DATA_W-1:0] diff_p1_q, diff_p1_d;
  logic [COEF_W-1:0] w_p1_q,    w_p1_d;
  logic [DATA_W-1:0] q_p1_q,    q_p1_d;
  logic [DATA_W-1:0] mu_p1_q,   mu_p1_d;

  logic              vld_p2_q,  vld_p2_d;
  logic [PROD_W-1:0] prod_p2_q, prod_p2_d;
  logic [DATA_W-1:0] sum_p2_q,  sum_p2_d;
  logic [DATA_W-1:0] q_p2_q,    q_p2_d;
  logic [DATA_W-1:0] mu_p2_q,   mu_p2_d;
  logic [K_W-1:0]    k_p2_q,    k_p2_d;

  logic              vld_p3_q,  vld_p3_d;
  logic [DATA_W-1:0] u_p3_q,    u_p3_d;
  logic [DATA_W-1:0] v_p3_q,    v_p3_d;
  logic [15:0]       done_q,    done_d;

`ifdef GS_BFLY_HALVE_EN
  logic              halve_p1_q, halve_p1_d;
  logic              halve_p2_q, halve_p2_d;
`endif

  assign advance   = !vld_p3_q || out_ready;
  assign in_ready  = advance;
  assign out_valid = vld_p3_q;
  assign u_out     = u_p3_q;
  assign v_out     = v_p3_q;
  assign busy      = vld_p1_q | vld_p2_q | vld_p3_q;
  assign done_cnt  = done_q;

  // ---- stage 1: modular sum and difference ----
  logic        [DATA_W:0]   sum_raw;
  logic signed [DATA_W+1:0] diff_raw;
  logic signed [DATA_W+1:0] diff_adj;
  logic signed [DATA_W+1:0] q_sx;

  always_comb begin
    sum_raw  = {1'b0, u} + {1'b0, v};
    q_sx     = $signed({2'b00, q});
    diff_raw = $signed({2'b00, u}) - $signed({2'b00, v});
    diff_adj = (diff_raw < 0) ? (diff_raw + q_sx) : diff_raw;

    vld_p1_d  = vld_p1_q;
    sum_p1_d  = sum_p1_q;
    diff_p1_d = diff_p1_q;
    w_p1_d    = w_p1_q;
    q_p1_d    = q_p1_q;
    mu_p1_d   = mu_p1_q;
`ifdef GS_BFLY_HALVE_EN
    halve_p1_d = halve_p1_q;
`endif
    if (advance) begin
      vld_p1_d  = in_valid;
      sum_p1_d  = (sum_raw >= {1'b0, q}) ? DATA_W'(sum_raw - {1'b0, q}) : sum_raw[DATA_W-1:0];
      diff_p1_d = diff_adj[DATA_W-1:0];
      w_p1_d    = w;
      q_p1_d    = q;
      mu_p1_d   = mu;
`ifdef GS_BFLY_HALVE_EN
      halve_p1_d = halve;
`endif
    end
  end

  // ---- stage 2: full-width product diff*w, modulus bit length ----
  always_comb begin
    vld_p2_d  = vld_p2_q;
    prod_p2_d = prod_p2_q;
    sum_p2_d  = sum_p2_q;
    q_p2_d    = q_p2_q;
    mu_p2_d   = mu_p2_q;
    k_p2_d    = k_p2_q;
`ifdef GS_BFLY_HALVE_EN
    halve_p2_d = halve_p2_q;
`endif
    if (advance) begin
      vld_p2_d  = vld_p1_q;
      prod_p2_d = PROD_W'(diff_p1_q) * PROD_W'(w_p1_q);
      sum_p2_d  = sum_p1_q;
      q_p2_d    = q_p1_q;
      mu_p2_d   = mu_p1_q;
      k_p2_d    = bit_len(q_p1_q);
`ifdef GS_BFLY_HALVE_EN
      halve_p2_d = halve_p1_q;
`endif
    end
  end

  // ---- stage 3: Barrett reduction, optional halving, result counter ----
  logic [DATA_W-1:0] u_res;
  logic [DATA_W-1:0] v_res;

  always_comb begin
    u_res = sum_p2_q;
    v_res = barrett_reduce(prod_p2_q, q_p2_q, mu_p2_q, k_p2_q);
`ifdef GS_BFLY_HALVE_EN
    if (halve_p2_q) begin
      u_res = half_mod(u_res, q_p2_q);
      v_res = half_mod(v_res, q_p2_q);
    end
`endif
    vld_p3_d = vld_p3_q;
    u_p3_d   = u_p3_q;
    v_p3_d   = v_p3_q;
    if (advance) begin
      vld_p3_d = vld_p2_q;
      u_p3_d   = u_res;
      v_p3_d   = v_res;
    end
    done_d = (vld_p3_q && out_ready) ? done_q + 16'd1 : done_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      vld_p3_q <= 1'b0;
      u_p3_q   <= '0;
      v_p3_q   <= '0;
      done_q   <= '0;
    end else begin
      vld_p1_q <= vld_p1_d;
      vld_p2_q <= vld_p2_d;
      vld_p3_q <= vld_p3_d;
      u_p3_q   <= u_p3_d;
      v_p3_q   <= v_p3_d;
      done_q   <= done_d;
    end
  end

  // Internal datapath registers carry no reset; their valid bits gate them.
  always_ff @(posedge clk) begin
    sum_p1_q  <= sum_p1_d;
    diff_p1_q <= diff_p1_d;
    w_p1_q    <= w_p1_d;
    q_p1_q    <= q_p1_d;
    mu_p1_q   <= mu_p1_d;
    prod_p2_q <= prod_p2_d;
    sum_p2_q  <= sum_p2_d;
    q_p2_q    <= q_p2_d;
    mu_p2_q   <= mu_p2_d;
    k_p2_q    <= k_p2_d;
`ifdef GS_BFLY_HALVE_EN
    halve_p1_q <= halve_p1_d;
    halve_p2_q <= halve_p2_d;
`endif
  end

endmodule

// File: tb/tb_gs_butterfly_pipe.sv
// Self-checking bench for gs_butterfly_pipe: directed and randomized beats against a
// plain modular-arithmetic reference model with an in-order scoreboard.
module tb_gs_butterfly_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [63:0] u, v, w, q, mu, u_out, v_out;
  logic [15:0] done_cnt;
`ifdef GS_BFLY_HALVE_EN
  logic        halve = 1'b0;
`endif

  always #5 clk = ~clk;

  gs_butterfly_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
`ifdef GS_BFLY_HALVE_EN
    .halve(halve),
`endif
    .u(u), .v(v), .w(w), .q(q), .mu(mu),
    .out_valid(out_valid), .out_ready(out_ready), .u_out(u_out), .v_out(v_out),
    .busy(busy), .done_cnt(done_cnt)
  );

  typedef struct {
    logic [63:0] eu;
    logic [63:0] ev;
    int          acc_cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          n_xfer = 0;
  int          n_acc = 0;
  int          first_xfer = 0;
  int          last_xfer = 0;
  bit          chk_lat = 1'b0;
  logic [63:0] last_u, last_v;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic logic [63:0] calc_mu(input logic [63:0] qq);
    int          k;
    logic [127:0] t;
    k = 0;
    for (int i = 0; i < 64; i++) if (qq[i]) k = i + 1;
    t = (128'd1 << (2 * k)) / {64'd0, qq};
    return t[63:0];
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [63:0] rand_below(input logic [63:0] qq);
    logic [127:0] r;
    r = {64'd0, rand64()} % {64'd0, qq};
    return r[63:0];
  endfunction

  function automatic logic [63:0] rand_q();
    logic [63:0] r;
    r = (rand64() & 64'h3FFF_FFFF_FFFF_FFFF) | 64'd1;
    if (r < 64'd3) r = 64'd3;
    return r;
  endfunction

  // Reference: plain modular arithmetic on wide integers.
  function automatic exp_t model(input logic [63:0] a, input logic [63:0] b,
                                 input logic [63:0] c, input logic [63:0] m, input bit h);
    logic [127:0] s, d, p, m_w, inv2;
    exp_t         e;
    m_w  = {64'd0, m};
    s    = ({64'd0, a} + {64'd0, b}) % m_w;
    d    = ({64'd0, a} + m_w - {64'd0, b}) % m_w;
    p    = (d * {64'd0, c}) % m_w;
    inv2 = (m_w + 128'd1) / 128'd2;
    if (h) begin
      s = (s * inv2) % m_w;
      p = (p * inv2) % m_w;
    end
    e.eu = s[63:0];
    e.ev = p[63:0];
    e.acc_cyc = 0;
    return e;
  endfunction

  task automatic set_beat(input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] c, input logic [63:0] m);
    u = a; v = b; w = c; q = m; mu = calc_mu(m);
    in_valid = 1'b1;
  endtask

  task automatic rand_beat(input logic [63:0] m);
    set_beat(rand_below(m), rand_below(m), rand_below(m), m);
  endtask

  task automatic tick();
    exp_t e;
    bit   h;
    #1;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("u_out", u_out, e.eu);
        check("v_out", v_out, e.ev);
        if (chk_lat) check("latency", 64'(cyc - e.acc_cyc), 64'd3);
        last_u = u_out;
        last_v = v_out;
        if (n_xfer == 0) first_xfer = cyc;
        last_xfer = cyc;
        n_xfer++;
      end
    end
    if (in_valid && in_ready) begin
      h = 1'b0;
`ifdef GS_BFLY_HALVE_EN
      h = halve;
`endif
      e = model(u, v, w, q, h);
      e.acc_cyc = cyc;
      exp_q.push_back(e);
      n_acc++;
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic drain(input int max_cyc);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < max_cyc && exp_q.size() > 0; i++) tick();
    if (exp_q.size() != 0) check("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done_cnt", 64'(done_cnt), 64'd0);
    check("rst_u_out", u_out, 64'd0);
    check("rst_v_out", v_out, 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    n_xfer = 0;
    #1;
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
  endtask

  initial begin
    in_valid = 1'b0; out_ready = 1'b1;
    u = '0; v = '0; w = '0; q = 64'd17; mu = calc_mu(64'd17);
    #2;
    do_reset();

    // single beat with u < v
    chk_lat = 1'b1;
    set_beat(64'd5, 64'd9, 64'd3, 64'd17);
    tick();
    drain(10);
    check("single_u", last_u, 64'd14);
    check("single_v", last_v, 64'd5);

    // boundary cases
    set_beat(64'd40, 64'd40, rand_below(64'd97), 64'd97);
    tick();
    drain(10);
    check("u_eq_v_vout", last_v, 64'd0);
    set_beat(64'd50, 64'd47, 64'd5, 64'd97);
    tick();
    drain(10);
    check("sum_eq_q_uout", last_u, 64'd0);
    set_beat(64'd96, 64'd96, 64'd96, 64'd97);
    tick();
    drain(10);
    check("max_u", last_u, 64'd95);
    check("max_v", last_v, 64'd0);

    // back-to-back streaming with the Mersenne modulus
    do_reset();
    for (int i = 0; i < 10; i++) begin
      rand_beat(64'h1FFF_FFFF_FFFF_FFFF);
      tick();
    end
    drain(20);
    check("stream_count", 64'(n_xfer), 64'd10);
    check("stream_consecutive", 64'(last_xfer - first_xfer), 64'd9);
    check("stream_done_cnt", 64'(done_cnt), 64'd10);

    // randomized handshake with interleaved moduli
    chk_lat = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) != 0) rand_beat(rand_q());
      else in_valid = 1'b0;
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain(20);
    check("mixed_done_cnt", 64'(done_cnt), 64'(n_xfer[15:0]));

    // backpressure: stall output for several cycles while feeding
    begin
      logic [63:0] hold_u, hold_v;
      bit          held;
      int          acc0, xfer0;
      held = 1'b0; hold_u = '0; hold_v = '0;
      acc0 = n_acc; xfer0 = n_xfer;
      out_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
        rand_beat(rand_q());
        #1;
        if (out_valid) begin
          check("bp_in_ready", 64'(in_ready), 64'd0);
          if (held) begin
            check("bp_hold_u", u_out, hold_u);
            check("bp_hold_v", v_out, hold_v);
          end else begin
            hold_u = u_out; hold_v = v_out; held = 1'b1;
          end
        end
        tick();
      end
      check("bp_stalled_valid", 64'(out_valid), 64'd1);
      drain(20);
      check("bp_no_loss", 64'(n_xfer - xfer0), 64'(n_acc - acc0));
      check("bp_done_cnt", 64'(done_cnt), 64'(n_xfer[15:0]));
    end

    // reset with three beats in flight
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_beat(rand_q());
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_done_cnt", 64'(done_cnt), 64'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("post_rst_quiet", 64'(out_valid | busy), 64'd0);
    end

`ifdef GS_BFLY_HALVE_EN
    halve = 1'b1;
    set_beat(64'd5, 64'd9, 64'd3, 64'd17);
    tick();
    drain(10);
    check("halve_u", last_u, 64'd7);
    check("halve_v", last_v, 64'd11);
    halve = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule
